// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard/stall controller.
package pipeline_pkg;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational hazard detection: load-use in ID and taken branch in MEM.
module hazard_detect
   import pipeline_pkg::*;
(
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_regwa,
   input  logic             mem_branch,
   input  logic             mem_zero,
   output logic             lu,
   output logic             br
);

   // Loads into $0 never create a real dependency.
   assign lu = ex_memread && (ex_regwa != REG_ZERO) &&
               ((ex_regwa == id_rs) || (ex_regwa == id_rt));
   assign br = mem_branch & mem_zero;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller with data-memory wait FSM and timeout watchdog.
// Optional stall performance counter enabled by PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl
   import pipeline_pkg::*;
#(
   parameter int WAIT_TIMEOUT = 255,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_regwa,
   input  logic             mem_branch,
   input  logic             mem_zero,
   input  logic             mem_memread,
   input  logic             mem_memwrite,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             pc_en,
   output logic             pc_sel_br,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_bubble,
   output logic             mem_err
`ifdef PIPELINE_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cnt
`endif
);

   localparam logic [8:0] TMO = 9'(WAIT_TIMEOUT);

   state_t     state;
   logic [8:0] wait_cnt;
   logic       memacc, mstall, timeout, lu, br;

   hazard_detect u_hazard (
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .ex_memread (ex_memread),
      .ex_regwa   (ex_regwa),
      .mem_branch (mem_branch),
      .mem_zero   (mem_zero),
      .lu         (lu),
      .br         (br)
   );

   assign memacc  = mem_memread | mem_memwrite;
   // Ready in the timeout cycle wins, so the access completes normally.
   assign timeout = (state == MEM_WAIT) && (wait_cnt == TMO) && !dmem_ready;
   assign mstall  = memacc && !dmem_ready && !timeout;

   always_comb begin
      dmem_req     = memacc;
      pc_en        = 1'b1;
      pc_sel_br    = 1'b0;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      exmem_flush  = 1'b0;
      memwb_bubble = 1'b0;
      if (rst) begin
         dmem_req     = 1'b0;
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_en      = 1'b0;
         exmem_en     = 1'b0;
         ifid_flush   = 1'b1;
         idex_flush   = 1'b1;
         exmem_flush  = 1'b1;
         memwb_bubble = 1'b1;
      end else if (mstall) begin
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_en      = 1'b0;
         exmem_en     = 1'b0;
         memwb_bubble = 1'b1;
      end else if (timeout) begin
         // Aborted load advances but must not reach the register file.
         memwb_bubble = 1'b1;
      end else if (br) begin
         pc_sel_br    = 1'b1;
         ifid_flush   = 1'b1;
         idex_flush   = 1'b1;
         exmem_flush  = 1'b1;
      end else if (lu) begin
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_flush   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         wait_cnt <= 9'd0;
         mem_err  <= 1'b0;
      end else begin
         if (timeout) mem_err <= 1'b1;
         case (state)
            RUN: if (mstall) begin
               state    <= MEM_WAIT;
               wait_cnt <= 9'd1;
            end
            MEM_WAIT: if (dmem_ready || timeout) begin
               state    <= RUN;
               wait_cnt <= 9'd0;
            end else if (wait_cnt != 9'h1ff) begin
               wait_cnt <= wait_cnt + 9'd1;
            end
            default: begin
               state    <= RUN;
               wait_cnt <= 9'd0;
            end
         endcase
      end
   end

`ifdef PIPELINE_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if ((mstall || lu) && (stall_cnt != '1))
         stall_cnt <= stall_cnt + CNT_W'(1);
   end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized self-checking bench for pipeline_ctrl against a cycle-level behavioural model.
module tb_pipeline_ctrl;

   localparam int WT = 4;
   localparam int CW = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_regwa;
   logic       ex_memread, mem_branch, mem_zero, mem_memread, mem_memwrite, dmem_ready;
   logic       dmem_req, pc_en, pc_sel_br, ifid_en, idex_en, exmem_en;
   logic       ifid_flush, idex_flush, exmem_flush, memwb_bubble, mem_err;
`ifdef PIPELINE_CTRL_PERF_EN
   logic [CW-1:0] stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // Model state: stall cycles spent on the current access, sticky error, stall count.
   int pend = 0;
   int err_m = 0;
   longint scnt_m = 0;

   pipeline_ctrl #(.WAIT_TIMEOUT(WT), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .ex_memread(ex_memread), .ex_regwa(ex_regwa),
      .mem_branch(mem_branch), .mem_zero(mem_zero),
      .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
      .dmem_ready(dmem_ready), .dmem_req(dmem_req), .pc_en(pc_en),
      .pc_sel_br(pc_sel_br), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .memwb_bubble(memwb_bubble), .mem_err(mem_err)
`ifdef PIPELINE_CTRL_PERF_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clr();
      rst = 0; id_rs = 0; id_rt = 0; ex_memread = 0; ex_regwa = 0;
      mem_branch = 0; mem_zero = 0; mem_memread = 0; mem_memwrite = 0; dmem_ready = 0;
   endtask

   // One cycle: check outputs mid-cycle against the model, then advance the model at the edge.
   task automatic tick();
      logic acc, to, ms, l, b;
      logic [9:0] e, g;
      @(negedge clk);
      acc = mem_memread | mem_memwrite;
      to  = (pend == WT) && !dmem_ready;
      ms  = acc && !dmem_ready && !to;
      l   = ex_memread && ex_regwa != 0 && (ex_regwa == id_rs || ex_regwa == id_rt);
      b   = mem_branch && mem_zero;
      // {req, pc_en, pc_sel, ifid_en, idex_en, exmem_en, ifid_fl, idex_fl, exmem_fl, bubble}
      if (rst)      e = 10'b0_0_0_000_111_1;
      else if (ms)  e = {acc, 9'b0_0_000_000_1};
      else if (to)  e = {acc, 9'b1_0_111_000_1};
      else if (b)   e = {acc, 9'b1_1_111_111_0};
      else if (l)   e = {acc, 9'b0_0_011_010_0};
      else          e = {acc, 9'b1_0_111_000_0};
      g = {dmem_req, pc_en, pc_sel_br, ifid_en, idex_en, exmem_en,
           ifid_flush, idex_flush, exmem_flush, memwb_bubble};
      chk("outs", 32'(g), 32'(e));
      chk("mem_err", 32'(mem_err), 32'(err_m));
`ifdef PIPELINE_CTRL_PERF_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(scnt_m));
`endif
      @(posedge clk);
      if (rst) begin
         pend = 0; err_m = 0; scnt_m = 0;
      end else begin
         if (to) err_m = 1;
         if ((ms || l) && scnt_m < (64'd1 << CW) - 1) scnt_m++;
         if (to || dmem_ready) pend = 0;
         else if (ms) pend++;
      end
      #1;
   endtask

   task automatic rand_in();
      int r;
      rst = ($urandom_range(0, 99) == 0);
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_regwa = 5'($urandom_range(0, 3));
      ex_memread = $urandom_range(0, 1) == 1;
      mem_branch = $urandom_range(0, 2) == 0;
      mem_zero = $urandom_range(0, 1) == 1;
      dmem_ready = $urandom_range(0, 2) == 0;
      // A stalled access stays in EX/MEM until it completes or aborts.
      if (pend == 0) begin
         r = $urandom_range(0, 3);
         mem_memread = (r == 0);
         mem_memwrite = (r == 1);
      end
   endtask

   initial begin
      clr();
      rst = 1;
      tick(); tick();
      chk("rst_mem_err", 32'(mem_err), 32'd0);
      chk("rst_dmem_req", 32'(dmem_req), 32'd0);
      clr();
      tick();

      // Load-use then normal flow.
      ex_memread = 1; ex_regwa = 8; id_rs = 8;
      tick();
      clr(); tick();
      // Load to $0: no stall.
      ex_memread = 1; ex_regwa = 0; id_rt = 0;
      tick();
      chk("lu_zero_pc_en", 32'(pc_en), 32'd1);
      // Taken branch, then branch together with load-use.
      clr(); mem_branch = 1; mem_zero = 1; tick();
      ex_memread = 1; ex_regwa = 3; id_rt = 3; tick();
      clr(); tick();

      // Three-cycle memory wait.
      rst = 1; tick(); clr();
      mem_memread = 1;
      repeat (3) tick();
      dmem_ready = 1; tick();
`ifdef PIPELINE_CTRL_PERF_EN
      chk("wait3_stall_cnt", 32'(stall_cnt), 32'd3);
`endif
      clr(); tick();
      // Zero-wait access.
      mem_memwrite = 1; dmem_ready = 1; tick();
      clr(); tick();

      // Timeout: WT stall cycles, then the abort cycle.
      mem_memread = 1;
      repeat (WT + 1) tick();
      chk("timeout_err", 32'(mem_err), 32'd1);
      clr(); tick();
      // Ready exactly in the timeout cycle completes normally.
      rst = 1; tick(); clr();
      mem_memread = 1;
      repeat (WT) tick();
      dmem_ready = 1; tick();
      chk("late_ready_err", 32'(mem_err), 32'd0);
      clr(); tick();

      // Reset in the second MEM_WAIT cycle.
      mem_memread = 1;
      repeat (WT + 1) tick();
      mem_memread = 1; tick(); tick();
      rst = 1; tick();
      rst = 0; tick();
      chk("rst_wait_err", 32'(mem_err), 32'd0);
      clr(); tick();

      repeat (3000) begin
         rand_in();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
